muldiv_unit: RTL and testbench

- Iterative multiply/divide unit that owns the HI/LO register pair for the MIPS core.
- It covers the MIPS operations the single-cycle ALU does not execute: mult, multu, div, divu, mfhi/mflo (through the hi/lo outputs), and mthi/mtlo.
- The datapath issues an operation with a start/busy/done handshake.
- The core stalls on any HI/LO access while busy is high.

---
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit that owns the MIPS HI/LO pair.
// Optional MULDIV_EARLY_OUT_EN: multiplies leave RUN once the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  // Handshake: start is sampled only while busy is low; busy stays high from
  // the cycle after the start edge until done pulses for one cycle with the
  // new HI/LO already visible. start while busy is dropped, never queued.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t             state, state_next;
  logic               div_q, neg_q, rs_neg_q, dz_q;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, opa;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dz_pulse_q;

  logic               last_iter;
  logic               is_signed;
  logic [WIDTH-1:0]   rs_abs, rt_abs;
  logic [WIDTH-1:0]   rem_shift;
  logic [WIDTH:0]     trial;
  logic               qbit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    last_iter = (cnt == CNT_W'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
    if (!div_q && ((opb >> 1) == '0))
      last_iter = 1'b1;
`else
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand conditioning at issue: signed ops run on magnitudes.
  always_comb begin
    is_signed = !op[0];
    rs_abs    = (is_signed && rs[WIDTH-1]) ? -rs : rs;
    rt_abs    = (is_signed && rt[WIDTH-1]) ? -rt : rt;
  end

  // Restoring divide step: partial remainder in acc, dividend shifts out of
  // opa's top while quotient bits shift into its bottom.
  always_comb begin
    rem_shift = {acc[WIDTH-2:0], opa[WIDTH-1]};
    trial     = {acc[WIDTH-1], rem_shift} - {1'b0, opb};
    qbit      = !trial[WIDTH];
  end

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quot_fix = neg_q ? -opa[WIDTH-1:0] : opa[WIDTH-1:0];
    rem_fix  = rs_neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= 1'b0;
      neg_q      <= 1'b0;
      rs_neg_q   <= 1'b0;
      dz_q       <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      opa        <= '0;
      opb        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_q    <= op[1];
            neg_q    <= is_signed && (rs[WIDTH-1] ^ rt[WIDTH-1]);
            rs_neg_q <= is_signed && rs[WIDTH-1];
            dz_q     <= op[1] && (rt == '0);
            cnt      <= '0;
            acc      <= '0;
            opa      <= {{WIDTH{1'b0}}, rs_abs};
            opb      <= rt_abs;
          end else begin
            if (mthi) hi_q <= rs;
            if (mtlo) lo_q <= rs;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (div_q) begin
            acc <= {{WIDTH{1'b0}}, (qbit ? trial[WIDTH-1:0] : rem_shift)};
            opa <= {{WIDTH{1'b0}}, opa[WIDTH-2:0], qbit};
          end else begin
            if (opb[0]) acc <= acc + opa;
            opa <= opa << 1;
            opb <= opb >> 1;
          end
        end
        FIX: begin
          done_q     <= 1'b1;
          dz_pulse_q <= dz_q;
          if (div_q) begin
            lo_q <= dz_q ? {WIDTH{1'b1}} : quot_fix;
            hi_q <= rem_fix;
          end else begin
            lo_q <= prod_fix[WIDTH-1:0];
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = (state != IDLE);
  assign done        = done_q;
  assign div_by_zero = dz_pulse_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus random ops
// compared against a 64-bit arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] rs, rt;
  logic [W-1:0] hi, lo;
  logic         busy, done, div_by_zero;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_hi, cur_lo;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] eh, output logic [W-1:0] el, output logic edz);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    edz = 1'b0;
    case (o)
      2'd0: begin p = sa * sb; el = W'(p); eh = W'(p >> 32); end
      2'd1: begin up = ua * ub; el = W'(up); eh = W'(up >> 32); end
      default: begin
        if (b == '0) begin
          el = '1; eh = a; edz = 1'b1;
        end else if (o == 2'd2) begin
          q = sa / sb; r = sa % sb; el = W'(q); eh = W'(r);
        end else begin
          el = W'(ua / ub); eh = W'(ua % ub);
        end
      end
    endcase
  endtask

  function automatic int exp_latency(input logic [1:0] o, input logic [W-1:0] b);
    int n;
    logic [W-1:0] m;
    n = W;
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      m = (!o[0] && b[W-1]) ? -b : b;
      n = 1;
      for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    end
`else
    m = b;
    if (o[1] && m[0]) n = W;
`endif
    return n + 2;
  endfunction

  // Issues one op; cycle k is the value seen just before the k-th edge after the start edge.
  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int restart_at, input int mtlo_at);
    logic [W-1:0] eh, el, gh, gl;
    logic edz, eb, ed, ez;
    int lat, seen;
    ref_model(o, a, b, eh, el, edz);
    exp_q.push_back(el);
    exp_q.push_back(eh);
    lat = exp_latency(o, b);
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b; mthi = 1'b0; mtlo = (mtlo_at == 0);
    @(posedge clk);
    seen = 0;
    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clk);
      start = (k == restart_at);
      mtlo  = (k == mtlo_at);
      if (start || mtlo) begin
        op = 2'($urandom); rs = $urandom; rt = $urandom;
      end
      eb = (k < lat);
      ed = (k == lat);
      ez = ed && edz;
      checks += 3;
      if (busy !== eb) begin errors++; $display("FAIL %s busy c%0d: got %b want %b", name, k, busy, eb); end
      if (done !== ed) begin errors++; $display("FAIL %s done c%0d: got %b want %b", name, k, done, ed); end
      if (div_by_zero !== ez) begin errors++; $display("FAIL %s dbz c%0d: got %b want %b", name, k, div_by_zero, ez); end
      if (done === 1'b1) seen++;
      if (k < lat) begin
        checks++;
        if (hi !== cur_hi || lo !== cur_lo) begin
          errors++;
          $display("FAIL %s hold c%0d: got %h/%h want %h/%h", name, k, hi, lo, cur_hi, cur_lo);
        end
      end else if (k == lat) begin
        gl = exp_q.pop_front();
        gh = exp_q.pop_front();
        checks += 2;
        if (lo !== gl) begin errors++; $display("FAIL %s lo: got %h want %h", name, lo, gl); end
        if (hi !== gh) begin errors++; $display("FAIL %s hi: got %h want %h", name, hi, gh); end
        cur_hi = gh;
        cur_lo = gl;
      end
    end
    start = 1'b0; mtlo = 1'b0;
    checks++;
    if (seen != 1) begin errors++; $display("FAIL %s done_count: got %0d want 1", name, seen); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = '0; rs = '0; rt = '0;
    #1;
    checks++;
    if ({hi, lo, busy, done, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h/%h %b%b%b want 0", hi, lo, busy, done, div_by_zero);
    end
    cur_hi = '0; cur_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult();
    run_op("mult_7x-3", 2'd0, 32'd7, 32'hFFFF_FFFD, -1, -1);
  endtask

  task automatic test_multu_restart();
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, -1);
  endtask

  task automatic test_div();
    run_op("div_-7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, -1, -1);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    run_op("div_neg_by_zero", 2'd2, 32'h8765_4321, 32'd0, -1, -1);
  endtask

  task automatic test_div_by_zero();
    run_op("divu_5/0", 2'd3, 32'd5, 32'd0, -1, -1);
  endtask

  task automatic test_mthi_mtlo();
    logic [W-1:0] v;
    @(negedge clk);
    mthi = 1'b1; rs = 32'h1234;
    @(negedge clk);
    mthi = 1'b0;
    checks++;
    if (hi !== 32'h1234 || lo !== cur_lo) begin
      errors++; $display("FAIL mthi: got %h/%h want %h/%h", hi, lo, 32'h1234, cur_lo);
    end
    cur_hi = 32'h1234;
    v = $urandom; mtlo = 1'b1; rs = v;
    @(negedge clk);
    mtlo = 1'b0;
    checks++;
    if (lo !== v || hi !== cur_hi) begin
      errors++; $display("FAIL mtlo: got %h/%h want %h/%h", hi, lo, cur_hi, v);
    end
    cur_lo = v;
    v = $urandom; mthi = 1'b1; mtlo = 1'b1; rs = v;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if (lo !== v || hi !== v) begin
      errors++; $display("FAIL mthi_mtlo: got %h/%h want %h/%h", hi, lo, v, v);
    end
    cur_hi = v; cur_lo = v;
    run_op("mtlo_busy", 2'd1, $urandom, $urandom, -1, 5);
    run_op("mtlo_with_start", 2'd0, $urandom | 32'h1, $urandom, -1, 0);
  endtask

  task automatic test_random();
    logic [1:0] o;
    logic [W-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = -W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op("random", o, a, b, -1, -1);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; rs = 32'hA5A5_5A5A;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    cur_hi = 32'hA5A5_5A5A; cur_lo = 32'hA5A5_5A5A;
    start = 1'b1; op = 2'd0; rs = 32'h0001_0003; rt = 32'h7000_0005;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({hi, lo, busy, done, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: got %h/%h %b%b%b want 0", hi, lo, busy, done, div_by_zero);
    end
    cur_hi = '0; cur_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    run_op("mult_3x4_after_reset", 2'd0, 32'd3, 32'd4, -1, -1);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_restart();
    test_div();
    test_div_by_zero();
    test_mthi_mtlo();
    test_random();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
